reset_seq: RTL and testbench
============================

// Module: reset_seq
// PURPOSE
//  Parametrised power-on/reset sequencer. Sits beside the PLL in the board top
//  and drives N_CH staggered active-high resets (CPU, video, peripherals...).
//  Holds every reset until PLL lock is stable, then releases the channels in
//  order. Re-arms on lock loss, external rst or a CPU software request, and
//  latches the cause of the last reset for firmware to read.
// PARAMETERS
//  N_CH         3   number of reset channels, 1..8
//  LOCK_FILTER  8   consecutive synced-lock-high cycles that count as stable, >=1
//  HOLD_CYCLES  16  cycles all channels stay asserted after lock is stable, >=1
//  STAGGER      4   cycles between release of channel k and channel k+1, >=1
// PORTS
//  clk25    in   1     system clock
//  rst      in   1     synchronous active-high reset; also an external re-sequence request
//  pll_lock in   1     PLL locked, asynchronous to clk25
//  sw_req   in   1     one-cycle pulse from CPU register write; requests re-sequence
//  rst_out  out  N_CH  active-high channel resets; bit 0 is released first
//  ready    out  1     1 when every channel is released
//  cause    out  2     last reset cause: 0 POR, 1 LOCK_LOSS, 2 EXT, 3 SW
// BEHAVIOUR
//  - One clock (clk25). rst is synchronous and active-high.
//  - Power-up (initial values): state ASSERT, rst_out all 1, ready 0, cause 0.
//  - On rst=1: next edge sets state ASSERT, rst_out all 1, ready 0, cause 2,
//    and clears all counters. While rst stays 1, the block stays in ASSERT.
//  - pll_lock passes through a 2-flop synchroniser to give lock_s.
//    lock_cnt counts consecutive lock_s=1 cycles and saturates at LOCK_FILTER.
//    lock_s=0 clears lock_cnt.
//  - FSM:
//    ASSERT:  rst_out all 1. Go to HOLD when lock_cnt==LOCK_FILTER.
//    HOLD:    count 0..HOLD_CYCLES-1. On the last count go to RELEASE with idx=0.
//    RELEASE: rst_out[idx] is cleared on entry. Every STAGGER cycles idx++ and
//             the next bit is cleared. After bit N_CH-1 is cleared go to RUN.
//    RUN:     ready=1.
//  - Release timing: rst_out[0] falls exactly HOLD_CYCLES cycles after HOLD is
//    entered. rst_out[k] falls k*STAGGER cycles after rst_out[0].
//    ready rises on the same edge as rst_out[N_CH-1] falls.
//  - Lock loss: lock_s=0 in HOLD, RELEASE or RUN -> next edge goes to ASSERT,
//    rst_out all 1, ready 0, cause 1. pll_lock pin low -> rst_out high within 3 edges.
//  - sw_req=1 in RELEASE or RUN -> ASSERT, cause 3. sw_req is ignored in
//    ASSERT and HOLD.
//  - If re-sequence events coincide, cause priority is rst > lock loss > sw_req.
//  - cause changes only on entry to ASSERT and holds until the next entry.
//  - Released channels never re-assert one at a time. Any abort re-asserts all
//    channels on the same edge.
//  - Counter width is $clog2(max(LOCK_FILTER,HOLD_CYCLES,STAGGER)+1).
//    No wrap-around: the lock counter saturates, and the other counters reset
//    on every state change.
//  - N_CH=1: RELEASE lasts one cycle, and rst_out[0] and ready change together.
// STRUCTURE
//  - Shared package: state encodings and cause codes. The cause codes are also
//    used by the CPU status-register decode.
//  - One sub-module: sync2 (2-flop synchroniser, with its reset value as a
//    parameter), reused for uart_rx and ps2 inputs.
//  - The FSM, counters and output registers stay in reset_seq. All outputs are
//    registered with no glitches.
// TESTING
//  1. Defaults, pll_lock rises at cycle 10 and rst=0 -> rst_out=111 until
//     cycle 10+2+8+16; bits 0,1,2 fall 4 cycles apart; ready with bit 2; cause=0.
//  2. In RUN, drop pll_lock for 1 cycle -> rst_out=111 within 3 edges, cause=1;
//     full sequence repeats after lock returns.
//  3. During RELEASE, after bit 0 is released, pulse rst -> next edge all bits=1,
//     cause=2; holding rst for 5 cycles keeps ASSERT.
//  4. In RUN, pulse sw_req -> all bits=1 next edge, cause=3; sw_req pulsed in
//     HOLD has no effect.
//  5. Same cycle rst=1, lock_s=0, sw_req=1 -> cause=2. Same cycle lock loss and
//     sw_req -> cause=1.
//  6. N_CH=1, HOLD_CYCLES=1, STAGGER=1, LOCK_FILTER=1 -> rst_out and ready
//     switch on the same edge; lock chattering at 1-cycle period never leaves ASSERT.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer. The cause codes also feed the CPU
// status-register decode.
package reset_seq_pkg;

  localparam logic [1:0] ST_ASSERT  = 2'd0;  // all channels held, waiting for stable lock
  localparam logic [1:0] ST_HOLD    = 2'd1;  // lock stable, fixed hold before first release
  localparam logic [1:0] ST_RELEASE = 2'd2;  // channels dropping one by one
  localparam logic [1:0] ST_RUN     = 2'd3;  // everything released

  typedef enum logic [1:0] {
    CAUSE_POR       = 2'd0,
    CAUSE_LOCK_LOSS = 2'd1,
    CAUSE_EXT       = 2'd2,
    CAUSE_SW        = 2'd3
  } cause_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input; the reset/power-up
// value is a parameter so the same block serves lock, uart_rx and ps2 pins.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q = RESET_VAL;
  logic sync_q = RESET_VAL;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_seq.sv
// Power-on/reset sequencer: holds N_CH resets until PLL lock is stable, then
// releases them in order; re-arms on lock loss, rst or a software request.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4
) (
  input  logic            clk25,
  input  logic            rst,
  input  logic            pll_lock,
  input  logic            sw_req,
  output logic [N_CH-1:0] rst_out,
  output logic            ready,
  output logic [1:0]      cause
);

  localparam int CW = $clog2(max3(LOCK_FILTER, HOLD_CYCLES, STAGGER) + 1);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CW-1:0] LOCK_MAX  = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_CH - 1);

  logic lock_s;

  logic [1:0]      state_q = ST_ASSERT;
  logic [1:0]      state_d;
  logic [CW-1:0]   lock_cnt_q = '0;
  logic [CW-1:0]   lock_cnt_d;
  logic [CW-1:0]   cnt_q = '0;
  logic [CW-1:0]   cnt_d;
  logic [IW-1:0]   idx_q = '0;
  logic [IW-1:0]   idx_d;
  logic [N_CH-1:0] rst_out_q = '1;
  logic [N_CH-1:0] rst_out_d;
  logic            ready_q = 1'b0;
  logic            ready_d;
  cause_e          cause_q = CAUSE_POR;
  cause_e          cause_d;

  logic   lock_lost;
  logic   sw_abort;
  cause_e abort_cause;

  sync2 #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk_i (clk25),
    .rst_i (rst),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lock_s) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  // Lock loss outranks a software request arriving on the same edge.
  always_comb begin
    lock_lost   = (state_q != ST_ASSERT) && !lock_s;
    sw_abort    = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && sw_req;
    abort_cause = lock_lost ? CAUSE_LOCK_LOSS : CAUSE_SW;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    cause_d   = cause_q;

    if (lock_lost || sw_abort) begin
      state_d   = ST_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      cause_d   = abort_cause;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          // Requiring lock_s as well keeps a chattering lock from slipping into HOLD.
          if ((lock_cnt_q == LOCK_MAX) && lock_s) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d   = ST_RELEASE;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = rst_out_q << 1;
            ready_d   = (N_CH == 1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q == STAG_LAST) begin
            idx_d     = idx_q + 1'b1;
            cnt_d     = '0;
            rst_out_d = rst_out_q << 1;
            if ((idx_q + 1'b1) == IDX_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          ready_d = 1'b1;
        end
        default: begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q    <= ST_ASSERT;
      lock_cnt_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      cause_q    <= CAUSE_EXT;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      cause_q    <= cause_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: a default-parameter instance and a minimal one
// (N_CH=LOCK_FILTER=HOLD_CYCLES=STAGGER=1), checked against a timestamp model.
module tb_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, lock_a = 1'b0, sw_a = 1'b0;
  logic [2:0] rst_out_a;
  logic       ready_a;
  logic [1:0] cause_a;

  logic       rst_1 = 1'b0, lock_1 = 1'b0, sw_1 = 1'b0;
  logic [0:0] rst_out_1;
  logic       ready_1;
  logic [1:0] cause_1;

  reset_seq u_dut_a (
    .clk25(clk), .rst(rst_a), .pll_lock(lock_a), .sw_req(sw_a),
    .rst_out(rst_out_a), .ready(ready_a), .cause(cause_a)
  );

  reset_seq #(.N_CH(1), .LOCK_FILTER(1), .HOLD_CYCLES(1), .STAGGER(1)) u_dut_1 (
    .clk25(clk), .rst(rst_1), .pll_lock(lock_1), .sw_req(sw_1),
    .rst_out(rst_out_1), .ready(ready_1), .cause(cause_1)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: a sequence is described only by the edge at which HOLD
  // began; every channel's release edge follows from that by arithmetic.
  int   p_n[2]  = '{3, 1};
  int   p_lf[2] = '{8, 1};
  int   p_hc[2] = '{16, 1};
  int   p_st[2] = '{4, 1};

  int         t = 0;
  bit         m_p1[2]  = '{0, 0};
  bit         m_p2[2]  = '{0, 0};
  int         m_run[2] = '{0, 0};
  bit         m_act[2] = '{0, 0};
  int         m_h[2]   = '{0, 0};
  logic [1:0] m_cause[2] = '{2'd0, 2'd0};

  task automatic m_step(input int i, input logic r, input logic pin, input logic sw);
    bit lsb, rel;
    lsb = m_p2[i];
    if (r) begin
      m_act[i] = 0; m_cause[i] = 2'd2; m_run[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
    end else begin
      rel = m_act[i] && ((t - 1) >= m_h[i] + p_hc[i]);
      if (m_act[i] && !lsb) begin
        m_act[i] = 0; m_cause[i] = 2'd1;
      end else if (rel && sw) begin
        m_act[i] = 0; m_cause[i] = 2'd3;
      end else if (!m_act[i] && (m_run[i] >= p_lf[i]) && lsb) begin
        m_act[i] = 1; m_h[i] = t;
      end
      m_run[i] = lsb ? ((m_run[i] + 1 > p_lf[i]) ? p_lf[i] : m_run[i] + 1) : 0;
      m_p2[i] = m_p1[i];
      m_p1[i] = pin;
    end
  endtask

  function automatic logic [7:0] m_rst(input int i);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < p_n[i]; k++)
      r[k] = !m_act[i] || (t < m_h[i] + p_hc[i] + k * p_st[i]);
    return r;
  endfunction

  function automatic logic m_ready(input int i);
    return m_act[i] && (t >= m_h[i] + p_hc[i] + (p_n[i] - 1) * p_st[i]);
  endfunction

  always @(posedge clk) begin
    t = t + 1;
    m_step(0, rst_a, lock_a, sw_a);
    m_step(1, rst_1, lock_1, sw_1);
  end

  always @(negedge clk) begin
    check("mdl_a_rst_out", 32'(rst_out_a), 32'(m_rst(0)));
    check("mdl_a_ready",   32'(ready_a),   32'(m_ready(0)));
    check("mdl_a_cause",   32'(cause_a),   32'(m_cause[0]));
    check("mdl_1_rst_out", 32'(rst_out_1), 32'(m_rst(1)));
    check("mdl_1_ready",   32'(ready_1),   32'(m_ready(1)));
    check("mdl_1_cause",   32'(cause_1),   32'(m_cause[1]));
  end

  typedef struct {
    logic       rst;
    logic       lock;
    logic       sw;
    int         cyc;
    logic [2:0] er;
    logic       ey;
    logic [1:0] ec;
  } vec_t;

  localparam int NV = 28;
  vec_t vt[NV];

  initial begin
    // Comments give the edge number each vector ends on.
    vt[0]  = '{0, 0, 0,  9, 3'b111, 0, 2'd0};  // 9
    vt[1]  = '{0, 1, 0, 26, 3'b111, 0, 2'd0};  // 35: lock seen at edge 10
    vt[2]  = '{0, 1, 0,  1, 3'b110, 0, 2'd0};  // 36 = 10+2+8+16
    vt[3]  = '{0, 1, 0,  3, 3'b110, 0, 2'd0};  // 39
    vt[4]  = '{0, 1, 0,  1, 3'b100, 0, 2'd0};  // 40
    vt[5]  = '{0, 1, 0,  4, 3'b000, 1, 2'd0};  // 44
    vt[6]  = '{0, 0, 0,  1, 3'b000, 1, 2'd0};  // 45: one-cycle lock drop
    vt[7]  = '{0, 1, 0,  2, 3'b111, 0, 2'd1};  // 47
    vt[8]  = '{0, 1, 0, 24, 3'b111, 0, 2'd1};  // 71
    vt[9]  = '{0, 1, 0,  1, 3'b110, 0, 2'd1};  // 72
    vt[10] = '{0, 1, 0,  8, 3'b000, 1, 2'd1};  // 80
    vt[11] = '{0, 1, 1,  1, 3'b111, 0, 2'd3};  // 81: sw in RUN
    vt[12] = '{0, 1, 0,  1, 3'b111, 0, 2'd3};  // 82: HOLD entered
    vt[13] = '{0, 1, 1,  1, 3'b111, 0, 2'd3};  // 83: sw in HOLD ignored
    vt[14] = '{0, 1, 0, 14, 3'b111, 0, 2'd3};  // 97
    vt[15] = '{0, 1, 0,  1, 3'b110, 0, 2'd3};  // 98 = 82+16
    vt[16] = '{1, 1, 0,  1, 3'b111, 0, 2'd2};  // 99: rst in RELEASE
    vt[17] = '{1, 1, 0,  4, 3'b111, 0, 2'd2};  // 103: rst held
    vt[18] = '{0, 1, 0, 26, 3'b111, 0, 2'd2};  // 129
    vt[19] = '{0, 1, 0,  1, 3'b110, 0, 2'd2};  // 130
    vt[20] = '{0, 1, 0,  8, 3'b000, 1, 2'd2};  // 138
    vt[21] = '{0, 0, 0,  1, 3'b000, 1, 2'd2};  // 139
    vt[22] = '{0, 0, 0,  1, 3'b000, 1, 2'd2};  // 140
    vt[23] = '{1, 0, 1,  1, 3'b111, 0, 2'd2};  // 141: rst + lock loss + sw
    vt[24] = '{0, 1, 0, 35, 3'b000, 1, 2'd2};  // 176
    vt[25] = '{0, 0, 0,  1, 3'b000, 1, 2'd2};  // 177
    vt[26] = '{0, 0, 0,  1, 3'b000, 1, 2'd2};  // 178
    vt[27] = '{0, 0, 1,  1, 3'b111, 0, 2'd1};  // 179: lock loss + sw

    #1;
    check("por_a_rst_out", 32'(rst_out_a), 32'h7);
    check("por_a_ready",   32'(ready_a),   32'h0);
    check("por_a_cause",   32'(cause_a),   32'h0);
    check("por_1_rst_out", 32'(rst_out_1), 32'h1);
    check("por_1_ready",   32'(ready_1),   32'h0);
    check("por_1_cause",   32'(cause_1),   32'h0);

    for (int i = 0; i < NV; i++) begin
      rst_a  = vt[i].rst;
      lock_a = vt[i].lock;
      sw_a   = vt[i].sw;
      repeat (vt[i].cyc) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_rst_out", i), 32'(rst_out_a), 32'(vt[i].er));
      check($sformatf("vec%0d_ready", i),   32'(ready_a),   32'(vt[i].ey));
      check($sformatf("vec%0d_cause", i),   32'(cause_a),   32'(vt[i].ec));
    end
    sw_a   = 1'b0;
    lock_a = 1'b1;

    // Minimal instance: a lock toggling every cycle must never start a sequence.
    rst_1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_1 = 1'b0;
    check("min_rst_cause", 32'(cause_1), 32'h2);
    for (int c = 0; c < 20; c++) begin
      lock_1 = ~lock_1;
      @(negedge clk);
      check("chatter_rst_out", 32'(rst_out_1), 32'h1);
      check("chatter_ready",   32'(ready_1),   32'h0);
    end
    lock_1 = 1'b0;
    repeat (3) @(negedge clk);
    lock_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("min_pre%0d_rst_out", k), 32'(rst_out_1), 32'h1);
      check($sformatf("min_pre%0d_ready", k),   32'(ready_1),   32'h0);
    end
    @(negedge clk);
    check("min_rel_rst_out", 32'(rst_out_1), 32'h0);
    check("min_rel_ready",   32'(ready_1),   32'h1);

    for (int c = 0; c < 2000; c++) begin
      rst_a = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 59) == 0) lock_a = ~lock_a;
      else if (!lock_a && $urandom_range(0, 5) == 0) lock_a = 1'b1;
      sw_a = ($urandom_range(0, 39) == 0);
      rst_1 = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 5) == 0) lock_1 = ~lock_1;
      else if (!lock_1 && $urandom_range(0, 2) == 0) lock_1 = 1'b1;
      sw_1 = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
